// File: rtl/cnn_accel_top.sv
// rtl/cnn_accel_top.sv - single-channel 3x3 conv + ReLU + requant + 2x2 maxpool inference core
module cnn_accel_core #(
    parameter int IN_H   = 8,
    parameter int IN_W   = 8,
    parameter int K      = 3,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int SHIFT  = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);
    localparam int OUT_H  = IN_H - K + 1;
    localparam int OUT_W  = IN_W - K + 1;
    localparam int P_H    = OUT_H / 2;
    localparam int P_W    = OUT_W / 2;
    localparam int IN_AW  = $clog2(IN_H * IN_W);
    localparam int W_AW   = $clog2(K * K);
    localparam int C_AW   = $clog2(OUT_H * OUT_W);
    localparam int P_AW   = $clog2(P_H * P_W);
    localparam int CW     = 8;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        IDLE, CONV_MAC, CONV_WB, POOL_RD, POOL_WB, DONE
    } state_t;

    logic signed [DATA_W-1:0] in_mem   [0:IN_H*IN_W-1];
    logic signed [DATA_W-1:0] w_mem    [0:K*K-1];
    logic        [7:0]        conv_mem [0:OUT_H*OUT_W-1];
    logic        [7:0]        pool_mem [0:P_H*P_W-1];

    state_t                   r_state;
    logic [CW-1:0]            r_i, r_j, r_kr, r_kc, r_p, r_q;
    logic [1:0]               r_pe;
    logic signed [ACC_W-1:0]  r_acc;
    logic [7:0]               r_max;

    logic [IN_AW-1:0]         w_in_addr;
    logic [W_AW-1:0]          w_w_addr;
    logic [C_AW-1:0]          w_conv_wr_addr;
    logic [C_AW-1:0]          w_conv_rd_addr;
    logic [P_AW-1:0]          w_pool_wr_addr;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic [ACC_W-1:0]         w_relu;
    logic [ACC_W-1:0]         w_shift;
    logic [7:0]               w_q;
    logic [7:0]               w_pool_val;
    logic                     w_k_last;

    assign w_in_addr      = IN_AW'((r_i + r_kr) * IN_W + r_j + r_kc);
    assign w_w_addr       = W_AW'(r_kr * K + r_kc);
    assign w_conv_wr_addr = C_AW'(r_i * OUT_W + r_j);
    assign w_conv_rd_addr = C_AW'((2 * r_p + r_pe[1]) * OUT_W + 2 * r_q + r_pe[0]);
    assign w_pool_wr_addr = P_AW'(r_p * P_W + r_q);

    assign w_prod     = in_mem[w_in_addr] * w_mem[w_w_addr];
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_k_last   = (r_kr == CW'(K-1)) && (r_kc == CW'(K-1));

    // Accumulator is non-negative after ReLU, so the arithmetic shift reduces to a logical one.
    assign w_relu     = r_acc[ACC_W-1] ? '0 : ACC_W'(r_acc);
    assign w_shift    = w_relu >> SHIFT;
    assign w_q        = (w_shift > ACC_W'(127)) ? 8'd127 : w_shift[7:0];
    assign w_pool_val = conv_mem[w_conv_rd_addr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            done    <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
            r_kr    <= '0;
            r_kc    <= '0;
            r_p     <= '0;
            r_q     <= '0;
            r_pe    <= '0;
            r_acc   <= '0;
            r_max   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= CONV_MAC;
                        done    <= 1'b0;
                        r_acc   <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_kr    <= '0;
                        r_kc    <= '0;
                        r_p     <= '0;
                        r_q     <= '0;
                        r_pe    <= '0;
                    end
                end
                CONV_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (w_k_last) begin
                        r_kr    <= '0;
                        r_kc    <= '0;
                        r_state <= CONV_WB;
                    end else if (r_kc == CW'(K-1)) begin
                        r_kc <= '0;
                        r_kr <= r_kr + CW'(1);
                    end else begin
                        r_kc <= r_kc + CW'(1);
                    end
                end
                CONV_WB: begin
                    r_acc <= '0;
                    if (r_j == CW'(OUT_W-1)) begin
                        r_j <= '0;
                        if (r_i == CW'(OUT_H-1)) begin
                            r_i     <= '0;
                            r_state <= POOL_RD;
                        end else begin
                            r_i     <= r_i + CW'(1);
                            r_state <= CONV_MAC;
                        end
                    end else begin
                        r_j     <= r_j + CW'(1);
                        r_state <= CONV_MAC;
                    end
                end
                POOL_RD: begin
                    if (r_pe == 2'd0 || w_pool_val > r_max)
                        r_max <= w_pool_val;
                    r_pe <= r_pe + 2'd1;
                    if (r_pe == 2'd3)
                        r_state <= POOL_WB;
                end
                POOL_WB: begin
                    if (r_q == CW'(P_W-1)) begin
                        r_q <= '0;
                        if (r_p == CW'(P_H-1)) begin
                            r_p     <= '0;
                            r_state <= DONE;
                            done    <= 1'b1;
                        end else begin
                            r_p     <= r_p + CW'(1);
                            r_state <= POOL_RD;
                        end
                    end else begin
                        r_q     <= r_q + CW'(1);
                        r_state <= POOL_RD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Result memories are never cleared; an aborting reset only suppresses the write at that edge.
    always_ff @(posedge clk) begin
        if (reset && r_state == CONV_WB)
            conv_mem[w_conv_wr_addr] <= w_q;
        if (reset && r_state == POOL_WB)
            pool_mem[w_pool_wr_addr] <= r_max;
    end
endmodule

module cnn_accel_top #(
    parameter int IN_H   = 8,
    parameter int IN_W   = 8,
    parameter int K      = 3,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int SHIFT  = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);
    cnn_accel_core #(
        .IN_H(IN_H), .IN_W(IN_W), .K(K),
        .DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT(SHIFT)
    ) CORE (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .done (done)
    );
endmodule

// File: tb/tb_cnn_accel_top.sv
// tb/tb_cnn_accel_top.sv - directed scoreboard bench for cnn_accel_top
module tb_cnn_accel_top;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic done;

    int checks = 0;
    int errors = 0;
    int in_img [64];
    int wt     [9];
    int conv_exp [36];
    int sb [$];
    int cyc;

    cnn_accel_top dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int mode);
        for (int k = 0; k < 64; k++) begin
            case (mode)
                0, 2:    in_img[k] = 1;
                1:       in_img[k] = k;
                3:       in_img[k] = 127;
                default: in_img[k] = int'($urandom_range(0, 40)) - 20;
            endcase
            dut.CORE.in_mem[k] = 8'(in_img[k]);
        end
        for (int k = 0; k < 9; k++) begin
            case (mode)
                0:       wt[k] = 1;
                1:       wt[k] = (k == 4) ? 1 : 0;
                2:       wt[k] = -1;
                3:       wt[k] = 127;
                default: wt[k] = int'($urandom_range(0, 10)) - 4;
            endcase
            dut.CORE.w_mem[k] = 8'(wt[k]);
        end
    endtask

    // Reference model: conv + ReLU + clamp (SHIFT = 0), then 2x2 max pool pushed to the scoreboard.
    task automatic push_expected();
        int acc;
        int m;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) begin
                acc = 0;
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++)
                        acc += in_img[(i+kr)*8 + j + kc] * wt[kr*3 + kc];
                conv_exp[i*6+j] = (acc < 0) ? 0 : ((acc > 127) ? 127 : acc);
            end
        for (int p = 0; p < 3; p++)
            for (int q = 0; q < 3; q++) begin
                m = 0;
                for (int d = 0; d < 4; d++)
                    if (conv_exp[(2*p + d/2)*6 + 2*q + d%2] > m)
                        m = conv_exp[(2*p + d/2)*6 + 2*q + d%2];
                sb.push_back(m);
            end
    endtask

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        push_expected();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int extra_start_at, input int reset_at, output int n);
        n = 0;
        while (n < 1000) begin
            if (n + 1 == extra_start_at) start = 1'b1;
            if (n + 1 == reset_at) reset = 1'b0;
            @(posedge clk);
            n++;
            #1;
            start = 1'b0;
            if (n == reset_at) begin
                reset = 1'b1;
                return;
            end
            if (done) break;
        end
    endtask

    task automatic check_results(input string tag);
        int e;
        for (int k = 0; k < 9; k++) begin
            e = sb.pop_front();
            chk($sformatf("%s pool[%0d]", tag, k), int'(dut.CORE.pool_mem[k]), e);
        end
        for (int k = 0; k < 36; k++)
            chk($sformatf("%s conv[%0d]", tag, k), int'(dut.CORE.conv_mem[k]), conv_exp[k]);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset done", int'(done), 0);
        chk("reset state", int'(dut.CORE.r_state), 0);
        chk("reset acc", int'(dut.CORE.r_acc), 0);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("reset beats start state", int'(dut.CORE.r_state), 0);
        chk("reset beats start done", int'(done), 0);
        start = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle without start", int'(dut.CORE.r_state), 0);

        load(0);
        launch();
        wait_done(-1, -1, cyc);
        chk("ones latency", cyc, 405);
        check_results("ones");

        load(1);
        launch();
        wait_done(-1, -1, cyc);
        chk("ramp latency", cyc, 405);
        chk("ramp pool0 const", int'(dut.CORE.pool_mem[0]), 18);
        chk("ramp pool8 const", int'(dut.CORE.pool_mem[8]), 54);
        check_results("ramp");

        load(2);
        launch();
        wait_done(-1, -1, cyc);
        chk("relu latency", cyc, 405);
        check_results("relu");

        load(3);
        launch();
        wait_done(-1, -1, cyc);
        chk("sat latency", cyc, 405);
        check_results("sat");

        load(4);
        repeat (5) @(posedge clk);
        #1;
        chk("hold in done", int'(done), 1);
        launch();
        chk("done drops on restart", int'(done), 0);
        wait_done(100, -1, cyc);
        chk("busy start ignored latency", cyc, 405);
        check_results("rand");
        launch();
        chk("done drops again", int'(done), 0);
        wait_done(-1, -1, cyc);
        chk("rerun latency", cyc, 405);
        check_results("rerun");

        load(1);
        launch();
        wait_done(-1, 200, cyc);
        chk("abort done", int'(done), 0);
        chk("abort state", int'(dut.CORE.r_state), 0);
        repeat (9) void'(sb.pop_front());
        repeat (3) @(posedge clk);
        #1;
        chk("abort stays idle", int'(dut.CORE.r_state), 0);
        launch();
        wait_done(-1, -1, cyc);
        chk("post-abort latency", cyc, 405);
        check_results("post-abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnn_accel_top.md
# cnn_accel_top

Top-level of a single-channel CNN inference core. It runs one 3×3 convolution over an 8×8 signed 8-bit feature map, then ReLU, requantisation and 2×2 max-pooling, and leaves a 3×3 result in an internal memory. Input image, weights and results live in internal memories that the bench preloads and reads by hierarchical reference. The block is controlled only by a `start`/`done` handshake.

## Interface
Parameters:
- `IN_H`, default 8: input rows.
- `IN_W`, default 8: input columns.
- `K`, default 3: kernel size; convolution is valid-only with stride 1.
- `DATA_W`, default 8: input and weight width, signed two's complement.
- `ACC_W`, default 20: accumulator width, signed.
- `SHIFT`, default 0: arithmetic right shift applied after ReLU.

Ports:
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low; low at a rising edge resets the block.
- `start`  in  1: request one inference; sampled only in IDLE or DONE.
- `done`  out  1: high while in DONE.

Internal storage, all row-major and reachable under instance `CORE`:
- `in_mem[0:63]`: 8-bit signed input image.
- `w_mem[0:8]`: 8-bit signed kernel weights.
- `conv_mem[0:35]`: 8-bit unsigned convolution results.
- `pool_mem[0:8]`: 8-bit unsigned pooled results.

## Operation
- Convolution output `conv[i][j]` for i, j in 0..5 is the sum over kr, kc of `in[i+kr][j+kc] * w[kr][kc]`.
  - Products are 16-bit signed, accumulated at ACC_W bits; no overflow is possible at these sizes.
- Requantisation: `q = clamp(max(acc,0) >>> SHIFT, 0, 127)`, written to `conv_mem[i*6+j]`.
- Pooling: `pool[p][q]` = max of `conv[2p..2p+1][2q..2q+1]`, written to `pool_mem[p*3+q]`.
- States: IDLE → CONV_MAC → CONV_WB → (next output or POOL_RD) → POOL_WB → (next window or DONE).
- CONV_MAC:
  - Lasts K*K = 9 cycles, one MAC per cycle, kernel order row-major.
  - Accumulator clears on entry.
- CONV_WB: 1 cycle; writes conv_mem and advances (i, j) row-major.
- POOL_RD: 4 cycles, reading one window element per cycle; the running max is initialised by the first read.
- POOL_WB: 1 cycle; writes pool_mem and advances (p, q).
- DONE:
  - `done` is held high.
  - `start` high returns the block to CONV_MAC and begins a new run; `done` drops on that edge.
  - Without `start`, the block stays in DONE.
- `start` in any busy state is ignored and never queued.
- Memory reads are combinational from registered addresses.

## Timing
- Reset value: state IDLE, `done` = 0, counters and accumulator = 0.
- Memory contents are not cleared by reset.
- `start` sampled high in IDLE at edge E0 moves the block to CONV_MAC.
- `done` rises after edge E0 + 405:
  - 36 × 10 = 360 convolution cycles;
  - 9 × 5 = 45 pooling cycles.
- All pool_mem writes are complete when `done` is first observed high.
- Reset low mid-run aborts at that edge: IDLE, `done` = 0.
  - conv_mem and pool_mem keep their partial contents.
  - A later `start` recomputes everything.
- `start` and `reset` low at the same edge: reset wins.

## Test plan
- All inputs = 1, all weights = 1, SHIFT = 0 → every conv_mem and pool_mem entry = 9; `done` high 405 cycles after `start`.
- `in[r][c] = r*8+c`, weight centre = 1, others 0 → `pool[p][q] = (2p+2)*8 + 2q + 2`, e.g. pool_mem[0] = 18, pool_mem[8] = 54.
- All inputs = 1, all weights = −1 → all pool_mem = 0 (ReLU).
- All inputs = 127, all weights = 127 → all pool_mem = 127 (saturation).
- `start` pulsed again at cycle 100 of a run → ignored; `done` still at cycle 405. Then `start` in DONE → `done` drops next cycle and rises again 405 cycles later with identical results.
- Reset low at cycle 200 → `done` = 0, state IDLE. A new `start` completes in 405 cycles with correct results.
